// File: rtl/axis_combine_pkg.sv
// Shared types and helpers for the packet-level AXI-Stream branch combiner.
// Round-robin search and index-width helpers live here so the top stays focused on control.
package axis_combine_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PASS,
      DROP
   } state_e;

   localparam int MAX_BRANCHES = 16;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Scans last+1 upward with wrap; iterating from the far end lets the nearest requester overwrite.
   function automatic logic [3:0] rr_next_grant(input logic [3:0] last,
                                                input logic [15:0] req,
                                                input int n);
      logic [4:0] cand;
      rr_next_grant = last;
      for (int k = MAX_BRANCHES; k >= 1; k--) begin
         if (k <= n) begin
            cand = 5'(last) + 5'(k);
            if (cand >= 5'(n)) begin
               cand = cand - 5'(n);
            end
            if (req[cand[3:0]]) begin
               rr_next_grant = cand[3:0];
            end
         end
      end
   endfunction

endpackage

// File: rtl/axis_branch_combine_if.sv
// Stream bundles for the combiner: a multi-branch input bundle and a single tagged output stream.
interface axis_branches_if #(
   parameter int DATA_W       = 64,
   parameter int NUM_BRANCHES = 2
);
   logic [NUM_BRANCHES*DATA_W-1:0] tdata;
   logic [NUM_BRANCHES-1:0]        tlast;
   logic [NUM_BRANCHES-1:0]        tvalid;
   logic [NUM_BRANCHES-1:0]        tready;

   modport master (output tdata, output tlast, output tvalid, input tready);
   modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

interface axis_stream_if #(
   parameter int DATA_W = 64,
   parameter int ID_W   = 1
);
   logic [DATA_W-1:0] tdata;
   logic              tlast;
   logic [ID_W-1:0]   tid;
   logic              tvalid;
   logic              tready;

   modport master (output tdata, output tlast, output tid, output tvalid, input tready);
   modport slave  (input tdata, input tlast, input tid, input tvalid, output tready);
endinterface

// File: rtl/axis_combine_skid.sv
// Two-entry registered output buffer; in_ready comes from a flop so out_ready never reaches it combinationally.
module axis_combine_skid #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
);

   logic [W-1:0] main_q, main_d;
   logic [W-1:0] skid_q, skid_d;
   logic         main_vld_q, main_vld_d;
   logic         skid_vld_q, skid_vld_d;
   logic         rdy_q, rdy_d;

   // The skid entry only fills when a beat arrives while the output is stalled.
   always_comb begin
      main_d     = main_q;
      skid_d     = skid_q;
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      if (skid_vld_q) begin
         if (out_ready) begin
            main_d     = skid_q;
            skid_vld_d = 1'b0;
         end
      end else if (in_valid && rdy_q) begin
         if (!main_vld_q || out_ready) begin
            main_d     = in_data;
            main_vld_d = 1'b1;
         end else begin
            skid_d     = in_data;
            skid_vld_d = 1'b1;
         end
      end else if (out_ready) begin
         main_vld_d = 1'b0;
      end
      rdy_d = !skid_vld_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         rdy_q      <= 1'b0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
         rdy_q      <= rdy_d;
      end
   end

   assign in_ready  = rdy_q;
   assign out_data  = main_q;
   assign out_valid = main_vld_q;

endmodule

// File: rtl/axis_branch_combine.sv
// Merges NUM_BRANCHES AXI-Stream inputs one whole packet at a time with packet-level round-robin,
// truncating packets longer than 2^MTU beats and discarding their remainder.
module axis_branch_combine
   import axis_combine_pkg::*;
#(
   parameter int DATA_W       = 64,
   parameter int NUM_BRANCHES = 2,
   parameter int MTU          = 10
) (
   input  logic            clk,
   input  logic            rst_n,
   axis_branches_if.slave  s_axis,
   axis_stream_if.master   m_axis,
   output logic            err_oversize
);

   localparam int ID_W   = idx_width(NUM_BRANCHES);
   localparam int SKID_W = DATA_W + 1 + ID_W;
   localparam logic [MTU:0] MAX_BEATS = {1'b1, {MTU{1'b0}}};

   state_e            state_q, state_d;
   logic [ID_W-1:0]   grant_q, grant_d;
   logic [ID_W-1:0]   last_grant_q, last_grant_d;
   logic [MTU:0]      beat_cnt_q, beat_cnt_d;
   logic              err_q, err_d;

   logic [DATA_W-1:0] sel_data;
   logic              sel_valid;
   logic              sel_last;
   logic              skid_in_valid;
   logic              skid_in_last;
   logic              skid_in_ready;
   logic [SKID_W-1:0] skid_out;

   assign sel_data  = s_axis.tdata[int'(grant_q)*DATA_W +: DATA_W];
   assign sel_valid = s_axis.tvalid[grant_q];
   assign sel_last  = s_axis.tlast[grant_q];

   // Only the granted branch ever sees tready; the last allowed beat of an overlong packet carries a forced tlast.
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_grant_d  = last_grant_q;
      beat_cnt_d    = beat_cnt_q;
      err_d         = 1'b0;
      skid_in_valid = 1'b0;
      skid_in_last  = sel_last;
      s_axis.tready = '0;
      case (state_q)
         IDLE: begin
            if (|s_axis.tvalid) begin
               grant_d    = ID_W'(rr_next_grant(4'(last_grant_q), 16'(s_axis.tvalid), NUM_BRANCHES));
               beat_cnt_d = '0;
               state_d    = PASS;
            end
         end
         PASS: begin
            s_axis.tready[grant_q] = skid_in_ready;
            skid_in_valid          = sel_valid;
            if (sel_valid && skid_in_ready) begin
               if (sel_last) begin
                  last_grant_d = grant_q;
                  beat_cnt_d   = '0;
                  state_d      = IDLE;
               end else if (beat_cnt_q + 1'b1 == MAX_BEATS) begin
                  skid_in_last = 1'b1;
                  err_d        = 1'b1;
                  state_d      = DROP;
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end
         DROP: begin
            s_axis.tready[grant_q] = 1'b1;
            if (sel_valid && sel_last) begin
               last_grant_d = grant_q;
               beat_cnt_d   = '0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= ID_W'(NUM_BRANCHES - 1);
         beat_cnt_q   <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
         err_q        <= err_d;
      end
   end

   axis_combine_skid #(
      .W (SKID_W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   ({grant_q, skid_in_last, sel_data}),
      .in_valid  (skid_in_valid),
      .in_ready  (skid_in_ready),
      .out_data  (skid_out),
      .out_valid (m_axis.tvalid),
      .out_ready (m_axis.tready)
   );

   assign {m_axis.tid, m_axis.tlast, m_axis.tdata} = skid_out;
   assign err_oversize = err_q;

endmodule

// File: tb/tb_axis_branch_combine.sv
// Directed bench for axis_branch_combine: three branches, MTU=4, per-branch source queues and an output capture queue.
module tb_axis_branch_combine;

   localparam int DW    = 32;
   localparam int NB    = 3;
   localparam int MTU_T = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic err;

   always #5 clk = ~clk;

   axis_branches_if #(.DATA_W(DW), .NUM_BRANCHES(NB)) s_if ();
   axis_stream_if   #(.DATA_W(DW), .ID_W(2))          m_if ();

   axis_branch_combine #(
      .DATA_W       (DW),
      .NUM_BRANCHES (NB),
      .MTU          (MTU_T)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_axis       (s_if),
      .m_axis       (m_if),
      .err_oversize (err)
   );

   int checks    = 0;
   int failures  = 0;
   int errCount  = 0;
   int srcCnt0   = 0;
   bit randomReady = 1'b0;

   logic [32:0] q0[$];
   logic [32:0] q1[$];
   logic [32:0] q2[$];
   logic [34:0] outQ[$];
   logic [34:0] expQ[$];

   logic [NB-1:0] srcFire  = '0;
   bit            prevStall = 1'b0;
   logic [35:0]   prevBeat  = '0;
   logic [32:0]   drvWord;

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] makeWord(input int b, input int p, input int i);
      return {4'hA, 4'(b), 8'(p), 16'(i)};
   endfunction

   function automatic void pushBeat(input int b, input logic [32:0] w);
      case (b)
         0: q0.push_back(w);
         1: q1.push_back(w);
         default: q2.push_back(w);
      endcase
   endfunction

   function automatic int qSize(input int b);
      case (b)
         0: return q0.size();
         1: return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic logic [32:0] qFront(input int b);
      case (b)
         0: return q0[0];
         1: return q1[0];
         default: return q2[0];
      endcase
   endfunction

   function automatic void qPop(input int b);
      case (b)
         0: void'(q0.pop_front());
         1: void'(q1.pop_front());
         default: void'(q2.pop_front());
      endcase
   endfunction

   // Queue one source packet of n beats on branch b, tlast on the final beat.
   task automatic applyStimulus(input int b, input int p, input int n);
      for (int i = 0; i < n; i++) begin
         pushBeat(b, {(i == n - 1), makeWord(b, p, i)});
      end
   endtask

   task automatic expectPacket(input int b, input int p, input int n);
      for (int i = 0; i < n; i++) begin
         expQ.push_back({2'(b), (i == n - 1), makeWord(b, p, i)});
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [34:0] got;
      checkVal({tag, "_count"}, 64'(outQ.size()), 64'(expQ.size()));
      for (int i = 0; i < expQ.size(); i++) begin
         got = (i < outQ.size()) ? outQ[i] : 'x;
         checkVal($sformatf("%s_beat%0d", tag, i), got, expQ[i]);
      end
      outQ.delete();
      expQ.delete();
   endtask

   task automatic waitOut(input int n);
      for (int c = 0; c < 2000 && outQ.size() < n; c++) begin
         @(negedge clk);
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic applyReset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      q0.delete();
      q1.delete();
      q2.delete();
      outQ.delete();
      expQ.delete();
      randomReady = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Source and sink driver: changes inputs just after the rising edge.
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         s_if.tvalid = '0;
         s_if.tlast  = '0;
         s_if.tdata  = '0;
         m_if.tready = 1'b0;
      end else begin
         for (int b = 0; b < NB; b++) begin
            if (srcFire[b] && qSize(b) > 0) begin
               qPop(b);
            end
            if (qSize(b) > 0) begin
               drvWord                 = qFront(b);
               s_if.tvalid[b]          = 1'b1;
               s_if.tlast[b]           = drvWord[32];
               s_if.tdata[b*DW +: DW]  = drvWord[31:0];
            end else begin
               s_if.tvalid[b] = 1'b0;
               s_if.tlast[b]  = 1'b0;
            end
         end
         m_if.tready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor on the falling edge: records handshakes and checks stall stability.
   always @(negedge clk) begin
      if (!rst_n) begin
         srcFire   = '0;
         prevStall = 1'b0;
      end else begin
         srcFire = s_if.tvalid & s_if.tready;
         if (srcFire[0]) srcCnt0++;
         if (prevStall) begin
            checkVal("stall_hold", {m_if.tvalid, m_if.tid, m_if.tlast, m_if.tdata}, prevBeat);
         end
         prevStall = m_if.tvalid && !m_if.tready;
         prevBeat  = {m_if.tvalid, m_if.tid, m_if.tlast, m_if.tdata};
         if (m_if.tvalid && m_if.tready) begin
            outQ.push_back({m_if.tid, m_if.tlast, m_if.tdata});
         end
         if (err) errCount++;
      end
   end

   initial begin
      int errBase;
      int srcBase;
      int c;
      s_if.tvalid = '0;
      s_if.tlast  = '0;
      s_if.tdata  = '0;
      m_if.tready = 1'b0;

      #3;
      rst_n = 1'b0;
      #1;
      checkVal("rst_m_tvalid", m_if.tvalid, 1'b0);
      checkVal("rst_s_tready", s_if.tready, 3'b000);
      checkVal("rst_err", err, 1'b0);
      checkVal("rst_tdata", m_if.tdata, 32'h0);
      checkVal("rst_tlast", m_if.tlast, 1'b0);
      checkVal("rst_tid", m_if.tid, 2'd0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] two simultaneous 4-beat packets");
      applyStimulus(0, 1, 4);
      applyStimulus(1, 1, 4);
      expectPacket(0, 1, 4);
      expectPacket(1, 1, 4);
      waitOut(8);
      checkOutput("t1");

      $display("[TB] three branches always valid, strict rotation");
      applyReset();
      for (int p = 1; p <= 3; p++) begin
         for (int b = 0; b < NB; b++) begin
            applyStimulus(b, p, 2);
            expectPacket(b, p, 2);
         end
      end
      waitOut(18);
      checkOutput("t2");

      $display("[TB] random output backpressure");
      applyReset();
      randomReady = 1'b1;
      applyStimulus(0, 1, 5);
      applyStimulus(1, 1, 3);
      applyStimulus(2, 1, 4);
      expectPacket(0, 1, 5);
      expectPacket(1, 1, 3);
      expectPacket(2, 1, 4);
      waitOut(12);
      checkOutput("t3");
      randomReady = 1'b0;

      $display("[TB] oversize packet truncation");
      applyReset();
      errBase = errCount;
      applyStimulus(0, 1, 20);
      applyStimulus(1, 2, 3);
      expectPacket(0, 1, 16);
      expectPacket(1, 2, 3);
      waitOut(19);
      checkOutput("t4");
      checkVal("t4_err_pulses", 64'(errCount - errBase), 64'd1);
      checkVal("t4_src0_drained", 64'(qSize(0)), 64'd0);

      $display("[TB] exactly 2^MTU beats is legal");
      applyReset();
      errBase = errCount;
      applyStimulus(0, 2, 16);
      expectPacket(0, 2, 16);
      waitOut(16);
      checkOutput("t5");
      checkVal("t5_err_pulses", 64'(errCount - errBase), 64'd0);

      $display("[TB] reset in the middle of a packet");
      applyReset();
      srcBase = srcCnt0;
      applyStimulus(0, 3, 6);
      c = 0;
      while (srcCnt0 - srcBase < 2 && c < 200) begin
         @(negedge clk);
         c++;
      end
      checkVal("t6_reached_beat3", 64'(srcCnt0 - srcBase >= 2), 64'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      q0.delete();
      q1.delete();
      q2.delete();
      #1;
      checkVal("t6_m_tvalid", m_if.tvalid, 1'b0);
      checkVal("t6_tdata", m_if.tdata, 32'h0);
      checkVal("t6_tlast", m_if.tlast, 1'b0);
      checkVal("t6_tid", m_if.tid, 2'd0);
      checkVal("t6_s_tready", s_if.tready, 3'b000);
      outQ.delete();
      expQ.delete();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(1, 4, 2);
      expectPacket(1, 4, 2);
      waitOut(2);
      checkOutput("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
